// File: rtl/peripheral_dbg_soc_dii_channel.sv
// DII channel types shared by the debug interconnect.
// A flit is {valid, last, data[15:0]}.
package peripheral_dbg_soc_dii_channel;

  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;

  function automatic dii_flit dii_flit_assemble(
    input logic        valid,
    input logic        last,
    input logic [15:0] data
  );
    dii_flit f;
    f.valid = valid;
    f.last  = last;
    f.data  = data;
    return f;
  endfunction

endpackage

// File: rtl/peripheral_dbg_soc_dii_buffer.sv
// DII flit FIFO with flit level and complete-packet count.
// PERIPHERAL_DBG_SOC_DII_BUFFER_FULLPACKET_EN selects store-and-forward.
module peripheral_dbg_soc_dii_buffer
  import peripheral_dbg_soc_dii_channel::*;
#(
  parameter int SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  dii_flit              flit_in,
  output logic                 flit_in_ready,
  output dii_flit              flit_out,
  input  logic                 flit_out_ready,
  output logic [$clog2(SIZE):0] level,
  output logic [$clog2(SIZE):0] packet_count
);

  localparam int AW = $clog2(SIZE);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(SIZE);

  logic [16:0]    mem_q [SIZE];

  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q;
  logic [AW-1:0]  rd_ptr_d;
  logic [LW-1:0]  level_q;
  logic [LW-1:0]  level_d;
  logic [LW-1:0]  pkt_q;
  logic [LW-1:0]  pkt_d;

  logic           empty;
  logic           full;
  logic           out_valid;
  logic           push;
  logic           pop;
  logic           pkt_inc;
  logic           pkt_dec;
  logic [16:0]    head;

  // Handshake status derived only from stored state.
  always_comb begin
    empty         = (level_q == '0);
    full          = (level_q == FULL);
    head          = mem_q[rd_ptr_q];
    flit_in_ready = !full;
`ifdef PERIPHERAL_DBG_SOC_DII_BUFFER_FULLPACKET_EN
    // A full buffer with no complete packet must still drain,
    // otherwise an oversized packet would wedge the channel.
    out_valid = !empty && ((pkt_q != '0) || full);
`else
    out_valid = !empty;
`endif
    push     = flit_in.valid && !full;
    pop      = out_valid && flit_out_ready;
    pkt_inc  = push && flit_in.last;
    pkt_dec  = pop && head[16];
    // Head is masked while empty so stale or unwritten
    // storage never reaches the output.
    flit_out = dii_flit_assemble(
      out_valid,
      head[16] & !empty,
      empty ? 16'h0000 : head[15:0]
    );
    level        = level_q;
    packet_count = pkt_q;
  end

  // Next-state for pointers, flit level and packet count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    unique case ({pkt_inc, pkt_dec})
      2'b10:   pkt_d = pkt_q + LW'(1);
      2'b01:   pkt_d = pkt_q - LW'(1);
      default: pkt_d = pkt_q;
    endcase
  end

  // State register; reset discards every stored flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
    end
  end

  // Flit storage; contents survive reset and are simply ignored.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {flit_in.last, flit_in.data};
    end
  end

endmodule

// File: tb/tb_peripheral_dbg_soc_dii_buffer.sv
// Bench for peripheral_dbg_soc_dii_buffer (SIZE=8).
// Scoreboard queue models contents, level and packet count.
module tb_peripheral_dbg_soc_dii_buffer;
  import peripheral_dbg_soc_dii_channel::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  dii_flit    flit_in;
  dii_flit    flit_out;
  logic       flit_in_ready;
  logic       flit_out_ready;
  logic [3:0] level;
  logic [3:0] packet_count;

  int n_chk = 0;
  int n_err = 0;

  logic [16:0] sb_q[$];
  int          pc_m = 0;
  logic        do_push = 1'b0;
  logic        do_pop = 1'b0;
  logic        push_ok = 1'b0;
  logic        exp_valid;
  logic [16:0] in_snap;

  always #5 clk = ~clk;

  peripheral_dbg_soc_dii_buffer #(
    .SIZE(DEPTH)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .flit_in       (flit_in),
    .flit_in_ready (flit_in_ready),
    .flit_out      (flit_out),
    .flit_out_ready(flit_out_ready),
    .level         (level),
    .packet_count  (packet_count)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Mid-cycle: compare status and popped head against the model.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      exp_valid = (sb_q.size() != 0);
`ifdef PERIPHERAL_DBG_SOC_DII_BUFFER_FULLPACKET_EN
      exp_valid = exp_valid && ((pc_m != 0) || (sb_q.size() == DEPTH));
`endif
      check("in_ready", 32'(flit_in_ready), 32'(sb_q.size() != DEPTH));
      check("out_valid", 32'(flit_out.valid), 32'(exp_valid));
      check("level", 32'(level), 32'(sb_q.size()));
      check("pkt_cnt", 32'(packet_count), 32'(pc_m));
      do_push = flit_in.valid && (sb_q.size() != DEPTH);
      do_pop  = exp_valid && flit_out_ready;
      in_snap = {flit_in.last, flit_in.data};
      if (do_pop) begin
        check("head", 32'({flit_out.last, flit_out.data}), 32'(sb_q[0]));
      end
    end
  end

  // Clock edge: apply the decided push/pop to the model.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_q.delete();
      pc_m    = 0;
      do_push = 1'b0;
      do_pop  = 1'b0;
      push_ok = 1'b0;
    end else begin
      push_ok = do_push;
      if (do_pop) begin
        if (sb_q[0][16]) pc_m--;
        void'(sb_q.pop_front());
      end
      if (do_push) begin
        sb_q.push_back(in_snap);
        if (in_snap[16]) pc_m++;
      end
      do_push = 1'b0;
      do_pop  = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic last, input logic [15:0] d);
    flit_in = dii_flit_assemble(1'b1, last, d);
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (push_ok) break;
    end
    check("send_accept", 32'(push_ok), 32'd1);
    flit_in = '0;
  endtask

  // Closes any open packet so store-and-forward can drain too.
  task automatic flush();
    flit_out_ready = 1'b1;
    send(1'b1, 16'h0F0F);
    for (int i = 0; i < 64; i++) begin
      if (sb_q.size() == 0) break;
      cyc();
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    check("drain_level", 32'(level), 32'd0);
    check("drain_pkt", 32'(packet_count), 32'd0);
  endtask

  initial begin
    rst            = 1'b0;
    flit_in        = '0;
    flit_out_ready = 1'b0;
    repeat (3) cyc();
    check("rst_level", 32'(level), 32'd0);
    check("rst_pkt", 32'(packet_count), 32'd0);
    check("rst_valid", 32'(flit_out.valid), 32'd0);
    check("rst_data", 32'(flit_out.data), 32'd0);
    rst = 1'b1;
    check("rel_ready", 32'(flit_in_ready), 32'd1);

    // Three-flit packet, downstream always ready.
    flit_out_ready = 1'b1;
    send(1'b0, 16'h1111);
    send(1'b0, 16'h2222);
    send(1'b1, 16'h3333);
    check("pkt_one", 32'(packet_count), 32'd1);
    repeat (4) cyc();
    check("pkt3_level", 32'(level), 32'd0);
    check("pkt3_pkt", 32'(packet_count), 32'd0);

    // Fill to full, hold a ninth flit, release one slot.
    flit_out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(1'b0, 16'h0100 + 16'(i));
    check("full_level", 32'(level), 32'd8);
    check("full_ready", 32'(flit_in_ready), 32'd0);
    check("full_valid", 32'(flit_out.valid), 32'd1);
    flit_in = dii_flit_assemble(1'b1, 1'b0, 16'h0999);
    repeat (2) cyc();
    check("held_level", 32'(level), 32'd8);
    flit_out_ready = 1'b1;
    cyc();
    flit_out_ready = 1'b0;
    check("one_pop", 32'(level), 32'd7);
    cyc();
    flit_in = '0;
    check("ninth_in", 32'(level), 32'd8);
    flush();

    // Simultaneous push and pop at level 1.
    flit_out_ready = 1'b0;
    send(1'b1, 16'h0001);
    check("lvl1", 32'(level), 32'd1);
    flit_in        = dii_flit_assemble(1'b1, 1'b0, 16'hBEEF);
    flit_out_ready = 1'b1;
    cyc();
    flit_in        = '0;
    flit_out_ready = 1'b0;
    check("pp_level", 32'(level), 32'd1);
    check("pp_head", 32'(flit_out.data), 32'h0000BEEF);
    flush();

    // Partial packet then its last flit.
    flit_out_ready = 1'b0;
    send(1'b0, 16'hA001);
    send(1'b0, 16'hA002);
`ifdef PERIPHERAL_DBG_SOC_DII_BUFFER_FULLPACKET_EN
    check("sf_hold", 32'(flit_out.valid), 32'd0);
`endif
    send(1'b1, 16'hA003);
    check("sf_release", 32'(flit_out.valid), 32'd1);
    flush();

    // Asynchronous reset in the middle of a packet.
    flit_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(1'b0, 16'h5000 + 16'(i));
    check("pre_rst", 32'(level), 32'd5);
    flit_in = dii_flit_assemble(1'b1, 1'b0, 16'h5005);
    #2;
    rst = 1'b0;
    #1;
    check("arst_level", 32'(level), 32'd0);
    check("arst_pkt", 32'(packet_count), 32'd0);
    check("arst_valid", 32'(flit_out.valid), 32'd0);
    flit_in = '0;
    repeat (2) cyc();
    rst = 1'b1;
    check("arst_ready", 32'(flit_in_ready), 32'd1);
    send(1'b1, 16'h7777);
    check("post_rst", 32'(level), 32'd1);
    flush();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      flit_in = dii_flit_assemble(
        ($urandom_range(0, 3) != 0),
        ($urandom_range(0, 3) == 0),
        16'($urandom())
      );
      flit_out_ready = ($urandom_range(0, 2) != 0);
      cyc();
    end
    flit_in = '0;
    flush();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/peripheral_dbg_soc_dii_buffer.md
PERIPHERAL_DBG_SOC_DII_BUFFER -- requirements
Module: peripheral_dbg_soc_dii_buffer

Interface
REQ-001 Parameter SIZE, default 8: flit depth; power of two, 2..256.
REQ-002 Port clk  input  1  sole clock; all state on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-low reset.
REQ-004 Port flit_in  input  dii_flit (18)  upstream flit {valid, last, data[15:0]}.
REQ-005 Port flit_in_ready  output  1  buffer accepts flit_in this cycle.
REQ-006 Port flit_out  output  dii_flit (18)  head flit to downstream stage.
REQ-007 Port flit_out_ready  input  1  downstream accepts flit_out this cycle.
REQ-008 Port level  output  $clog2(SIZE)+1  flits currently stored, 0..SIZE.
REQ-009 Port packet_count  output  $clog2(SIZE)+1  complete packets stored (last flit present).

Function
REQ-010 Push when flit_in.valid && flit_in_ready; pop when flit_out.valid && flit_out_ready.
REQ-011 flit_in_ready = (level != SIZE); combinational from state only, never from flit_in.
REQ-012 Storage: SIZE-entry array of {last, data}; read/write pointers wrap modulo SIZE.
REQ-013 flit_out.data and flit_out.last driven combinationally from head entry; zero-latency read, 1-cycle write-to-visible latency.
REQ-014 Push and pop in same cycle: both occur; level unchanged; legal at any non-full level, incl. level 1.
REQ-015 level: +1 on push only, -1 on pop only, unchanged otherwise.
REQ-016 packet_count: +1 on push of last=1, -1 on pop of last=1; both same cycle -> unchanged.
REQ-017 Empty (level 0): flit_out.valid = 0; flit_out.data/last are don't-care but must not be X after reset.
REQ-018 Full (level SIZE): flit_in_ready = 0; flit_in ignored; pop still allowed.
REQ-019 Flit order preserved exactly; no flit dropped, duplicated or reordered.
REQ-020 flit_out.valid must not depend combinationally on flit_out_ready.

Reset
REQ-021 On rst low (async): pointers, level, packet_count = 0; flit_out.valid = 0; flit_in_ready = 1 after release.
REQ-022 Reset mid-packet discards all stored flits and partial packets; storage array need not be cleared.
REQ-023 First push accepted on first rising clk edge after rst deasserts.

Configuration
REQ-024 Macro PERIPHERAL_DBG_SOC_DII_BUFFER_FULLPACKET_EN selects store-and-forward mode.
REQ-025 Defined: flit_out.valid = (level != 0) && ((packet_count != 0) || (level == SIZE)); full-without-last releases flits to prevent deadlock.
REQ-026 Undefined: flit_out.valid = (level != 0) (cut-through); packet_count still maintained.

Structure
REQ-027 dii_flit typedef and dii_flit_assemble reused from existing package peripheral_dbg_soc_dii_channel; no new typedef in the module.
REQ-028 No sub-module; pointer/counter logic and storage are flat in one module.

Verification
REQ-029 Reset, 3-flit packet 0x1111,0x2222,0x3333(last), ready=1: output same order, level returns 0, packet_count 1->0.
REQ-030 SIZE=8, flit_out_ready=0, push 8 flits: level=8, flit_in_ready=0 at cycle 8, 9th flit held and accepted after one pop.
REQ-031 level=1, simultaneous push 0xBEEF and pop: level stays 1, next head = 0xBEEF.
REQ-032 FULLPACKET_EN: push 0xA001,0xA002 (no last): flit_out.valid=0; push 0xA003 last: valid=1 next cycle.
REQ-033 FULLPACKET_EN, SIZE=8, 8 flits no last: flit_out.valid=1 at full; drains 8 flits.
REQ-034 Assert rst mid-packet at level=5: level=0, packet_count=0, flit_out.valid=0 immediately.
